// File: rtl/kronos_types.sv
// ============================================================================
//  Module      : kronos_types
//  Description : Shared types and constants for the Kronos front end.
//  Revision    : 1.0 - fetch FSM state enum and prefetch queue entry added
// ============================================================================
`default_nettype none

package kronos_types;

    // PC increment between consecutive instruction words
    localparam logic [31:0] FOUR = 32'd4;

    // Prefetch controller states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    // One prefetch queue slot: fetch address and the word returned for it
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/kronos_prefetch_fifo.sv
// ============================================================================
//  Module      : kronos_prefetch_fifo
//  Description : Two-entry, 64-bit FIFO. Slot 0 is always the head, so the
//                output is a plain register with no read multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kronos_prefetch_fifo (
    input  logic        clk,
    input  logic        rstz,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [63:0] din,
    output logic [63:0] dout,
    output logic [1:0]  count
);

    logic [63:0] e0_q, e0_d;
    logic [63:0] e1_q, e1_d;
    logic [1:0]  count_q, count_d;

    // Shift-style update: a pop moves slot 1 into slot 0; clear wins over all
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (clear) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_d    = din;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        e1_d    = din;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q != 2'd0) begin
                        e0_d    = e1_q;
                        count_d = count_q - 2'd1;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = din;
                    end else begin
                        // A pop of an empty queue is meaningless; treat as push
                        e0_d    = din;
                        count_d = 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Queue storage and occupancy registers
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            e0_q    <= 64'd0;
            e1_q    <= 64'd0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign dout  = e0_q;
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/kronos_prefetch.sv
// ============================================================================
//  Module      : kronos_prefetch
//  Description : Instruction fetch stage. Single-outstanding-request bus
//                master feeding a 2-entry prefetch queue towards decode, with
//                branch redirect that flushes the queue and drops any
//                in-flight response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kronos_prefetch
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_ir,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;

    logic         push, pop, clear, room;
    logic [1:0]   count;
    logic [2:0]   level;
    logic [31:0]  target;
    logic [31:0]  addr_inc;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign target   = branch_target & ~32'h3;
    assign addr_inc = addr_q + FOUR;

    // Occupancy after this cycle's push/pop decides whether another fetch fits
    assign level = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    assign room  = (level <= 3'd1);

    // FSM state register
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (branch || room) state_d = REQ;
            end
            REQ: begin
                if (branch && !instr_ack)                 state_d = DISCARD;
                else if (instr_ack && !branch && !room)   state_d = IDLE;
            end
            DISCARD: begin
                if (instr_ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and queue controls; a branch suppresses both push and pop
    always_comb begin
        instr_req = (state_q != IDLE);
        fetch_vld = (count != 2'd0);
        push      = (state_q == REQ) && instr_ack && !branch;
        pop       = fetch_vld && fetch_rdy && !branch;
        clear     = branch;
    end

    // Next fetch PC and bus address; the bus address only moves when no
    // request is pending or the pending one is being acked
    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        case (state_q)
            IDLE: begin
                if (branch) begin
                    pc_d   = target;
                    addr_d = target;
                end else begin
                    addr_d = pc_q;
                end
            end
            REQ: begin
                if (instr_ack && !branch) begin
                    pc_d = addr_inc;
                    if (room) addr_d = addr_inc;
                end else if (instr_ack && branch) begin
                    pc_d   = target;
                    addr_d = target;
                end else if (branch) begin
                    pc_d = target;
                end
            end
            DISCARD: begin
                if (branch) pc_d = target;
                if (instr_ack) addr_d = branch ? target : pc_q;
            end
            default: begin
            end
        endcase
    end

    // PC and bus address registers
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            pc_q   <= BOOT_ADDR;
            addr_q <= BOOT_ADDR;
        end else begin
            pc_q   <= pc_d;
            addr_q <= addr_d;
        end
    end

    assign instr_addr    = addr_q;
    assign push_entry.pc = addr_q;
    assign push_entry.ir = instr_data;

    kronos_prefetch_fifo u_fifo (
        .clk   (clk),
        .rstz  (rstz),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (push_entry),
        .dout  (head),
        .count (count)
    );

    assign fetch_pc = head.pc;
    assign fetch_ir = head.ir;

endmodule

`default_nettype wire

// File: tb/tb_kronos_prefetch.sv
// ============================================================================
//  Module      : tb_kronos_prefetch
//  Description : Directed bench for kronos_prefetch. Two instances (default
//                boot address and a boot address near the top of memory)
//                share all stimulus. A stream-level model predicts the PC of
//                every instruction handed to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kronos_prefetch;

    localparam logic [31:0] BOOT_LO = 32'h0000_0000;
    localparam logic [31:0] BOOT_HI = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr, instr_addr_hi;
    logic        instr_req, instr_req_hi;
    logic [31:0] instr_data, instr_data_hi;
    logic        instr_ack;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] fetch_pc, fetch_pc_hi;
    logic [31:0] fetch_ir, fetch_ir_hi;
    logic        fetch_vld, fetch_vld_hi;
    logic        fetch_rdy;
    logic        hold;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    kronos_prefetch #(.BOOT_ADDR(BOOT_LO)) dut (
        .clk           (clk),
        .rstz          (rstz),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr_data    (instr_data),
        .instr_ack     (instr_ack),
        .branch        (branch),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc),
        .fetch_ir      (fetch_ir),
        .fetch_vld     (fetch_vld),
        .fetch_rdy     (fetch_rdy)
    );

    kronos_prefetch #(.BOOT_ADDR(BOOT_HI)) dut_hi (
        .clk           (clk),
        .rstz          (rstz),
        .instr_addr    (instr_addr_hi),
        .instr_req     (instr_req_hi),
        .instr_data    (instr_data_hi),
        .instr_ack     (instr_ack),
        .branch        (branch),
        .branch_target (branch_target),
        .fetch_pc      (fetch_pc_hi),
        .fetch_ir      (fetch_ir_hi),
        .fetch_vld     (fetch_vld_hi),
        .fetch_rdy     (fetch_rdy)
    );

    // Instruction memory contents as a function of address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; then act as the bus: ack in the same cycle as the
    // request unless hold is set, returning the memory word at the address
    task automatic cycle();
        @(posedge clk);
        #1;
        instr_ack     = instr_req & ~hold;
        instr_data    = memf(instr_addr);
        instr_data_hi = memf(instr_addr_hi);
    endtask

    task automatic do_reset();
        rstz      = 1'b0;
        branch    = 1'b0;
        instr_ack = 1'b0;
        cycle();
        cycle();
        rstz = 1'b1;
    endtask

    // Stream model: decode must see BOOT, BOOT+4, ... and after each branch
    // target, target+4, ...; also checks bus hold and head stability rules
    logic [31:0] exp_pc, exp_pc_hi;
    logic        pend_v, head_v;
    logic [31:0] pend_addr, head_pc, head_ir;

    always @(negedge clk) begin
        if (!rstz) begin
            exp_pc    = BOOT_LO;
            exp_pc_hi = BOOT_HI;
            pend_v    = 1'b0;
            head_v    = 1'b0;
        end else begin
            if (pend_v) begin
                chk("bus_req_held", {31'd0, instr_req}, 32'd1);
                chk("bus_addr_held", instr_addr, pend_addr);
            end
            if (head_v) begin
                chk("head_vld_held", {31'd0, fetch_vld}, 32'd1);
                chk("head_pc_held", fetch_pc, head_pc);
                chk("head_ir_held", fetch_ir, head_ir);
            end
            if (fetch_vld && fetch_rdy && !branch) begin
                chk("pop_pc", fetch_pc, exp_pc);
                chk("pop_ir", fetch_ir, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (fetch_vld_hi && fetch_rdy && !branch) begin
                chk("pop_pc_hi", fetch_pc_hi, exp_pc_hi);
                chk("pop_ir_hi", fetch_ir_hi, memf(exp_pc_hi));
                exp_pc_hi = exp_pc_hi + 32'd4;
            end
            if (branch) begin
                exp_pc    = branch_target & ~32'h3;
                exp_pc_hi = branch_target & ~32'h3;
            end
            pend_v    = instr_req && !instr_ack;
            pend_addr = instr_addr;
            head_v    = fetch_vld && !fetch_rdy && !branch;
            head_pc   = fetch_pc;
            head_ir   = fetch_ir;
        end
    end

    initial begin
        rstz          = 1'b0;
        fetch_rdy     = 1'b1;
        hold          = 1'b0;
        branch        = 1'b0;
        branch_target = 32'd0;
        instr_ack     = 1'b0;
        instr_data    = 32'd0;
        instr_data_hi = 32'd0;

        // Reset state
        cycle();
        cycle();
        chk("rst_req", {31'd0, instr_req}, 32'd0);
        chk("rst_addr", instr_addr, 32'h0);
        chk("rst_addr_hi", instr_addr_hi, 32'hFFFF_FFF8);
        chk("rst_vld", {31'd0, fetch_vld}, 32'd0);
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_ir", fetch_ir, 32'h0);

        // Streaming with single-cycle acks and decode always ready
        rstz = 1'b1;
        cycle();
        chk("boot_req", {31'd0, instr_req}, 32'd1);
        chk("boot_addr", instr_addr, 32'h0);
        chk("boot_addr_hi", instr_addr_hi, 32'hFFFF_FFF8);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stream_pc", fetch_pc, 32'(i * 4));
            chk("stream_req", {31'd0, instr_req}, 32'd1);
            chk("stream_pc_hi", fetch_pc_hi, 32'hFFFF_FFF8 + 32'(i * 4));
        end

        // Decode stalled: queue fills with two words, then drains in order
        fetch_rdy = 1'b0;
        do_reset();
        cycle();
        cycle();
        cycle();
        chk("full_req_drop", {31'd0, instr_req}, 32'd0);
        chk("full_vld", {31'd0, fetch_vld}, 32'd1);
        chk("full_head", fetch_pc, 32'h0);
        cycle();
        chk("full_req_still", {31'd0, instr_req}, 32'd0);
        fetch_rdy = 1'b1;
        cycle();
        chk("drain_pc4", fetch_pc, 32'h4);
        chk("drain_req", {31'd0, instr_req}, 32'd1);
        chk("drain_addr8", instr_addr, 32'h8);
        cycle();
        chk("drain_pc8", fetch_pc, 32'h8);

        // Branch while an ack is pending: old word acked and dropped
        fetch_rdy = 1'b1;
        do_reset();
        cycle();
        cycle();
        hold = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("stall_addr", instr_addr, 32'h8);
        chk("stall_req", {31'd0, instr_req}, 32'd1);
        branch        = 1'b1;
        branch_target = 32'h0000_0100;
        cycle();
        branch = 1'b0;
        chk("disc_vld", {31'd0, fetch_vld}, 32'd0);
        chk("disc_addr", instr_addr, 32'h8);
        chk("disc_req", {31'd0, instr_req}, 32'd1);
        hold = 1'b0;
        cycle();
        chk("disc_ack_addr", instr_addr, 32'h8);
        cycle();
        chk("redir_addr", instr_addr, 32'h100);
        chk("redir_vld", {31'd0, fetch_vld}, 32'd0);
        cycle();
        chk("redir_pc", fetch_pc, 32'h100);
        chk("redir_ir", fetch_ir, memf(32'h100));

        // Branch coincident with ack and a decode pop (unaligned target)
        fetch_rdy = 1'b0;
        do_reset();
        cycle();
        cycle();
        branch        = 1'b1;
        branch_target = 32'h0000_0203;
        fetch_rdy     = 1'b1;
        cycle();
        branch = 1'b0;
        chk("bra_ack_vld", {31'd0, fetch_vld}, 32'd0);
        chk("bra_ack_req", {31'd0, instr_req}, 32'd1);
        chk("bra_ack_addr", instr_addr, 32'h200);
        cycle();
        chk("bra_ack_pc", fetch_pc, 32'h200);

        // Branch with a full queue and a decode pop, from IDLE
        fetch_rdy = 1'b0;
        do_reset();
        cycle();
        cycle();
        cycle();
        chk("bra_full_vld", {31'd0, fetch_vld}, 32'd1);
        branch        = 1'b1;
        branch_target = 32'h0000_0300;
        fetch_rdy     = 1'b1;
        cycle();
        branch = 1'b0;
        chk("bra_full_empty", {31'd0, fetch_vld}, 32'd0);
        chk("bra_full_req", {31'd0, instr_req}, 32'd1);
        chk("bra_full_addr", instr_addr, 32'h300);
        cycle();
        chk("bra_full_pc", fetch_pc, 32'h300);

        // Reset mid-request with one queued entry
        fetch_rdy = 1'b0;
        do_reset();
        cycle();
        hold = 1'b1;
        cycle();
        chk("mid_vld", {31'd0, fetch_vld}, 32'd1);
        chk("mid_req", {31'd0, instr_req}, 32'd1);
        rstz = 1'b0;
        #1;
        chk("async_vld", {31'd0, fetch_vld}, 32'd0);
        chk("async_req", {31'd0, instr_req}, 32'd0);
        chk("async_pc", fetch_pc, 32'h0);
        chk("async_addr", instr_addr, 32'h0);
        chk("async_addr_hi", instr_addr_hi, 32'hFFFF_FFF8);
        hold      = 1'b0;
        fetch_rdy = 1'b1;
        cycle();
        rstz = 1'b1;
        cycle();
        chk("restart_req", {31'd0, instr_req}, 32'd1);
        chk("restart_addr", instr_addr, 32'h0);
        cycle();
        chk("restart_pc", fetch_pc, 32'h0);
        chk("restart_vld", {31'd0, fetch_vld}, 32'd1);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
